// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encodings,
// the NOP word and PC helpers.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FS_START   = 2'd0,
        FS_FETCH   = 2'd1,
        FS_HOLD    = 2'd2,
        FS_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID output slot plus a one-entry skid buffer that catches a word
// returned while decode is stalled on the current slot contents.
module if_id_register
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic        skid_load,
    input  logic [31:0] word,
    input  logic [31:0] pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_four
);

    logic        slot_valid_reg;
    logic [31:0] slot_instr_reg;
    logic [31:0] slot_pc_reg;
    logic [31:0] slot_pc_four_reg;

    logic        skid_valid_reg;
    logic [31:0] skid_instr_reg;
    logic [31:0] skid_pc_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid_reg   <= 1'b0;
            slot_instr_reg   <= NOP_WORD;
            slot_pc_reg      <= 32'h0;
            slot_pc_four_reg <= 32'h0;
            skid_valid_reg   <= 1'b0;
            skid_instr_reg   <= NOP_WORD;
            skid_pc_reg      <= 32'h0;
        end else if (flush) begin
            slot_valid_reg <= 1'b0;
            slot_instr_reg <= NOP_WORD;
            skid_valid_reg <= 1'b0;
        end else begin
            if (load) begin
                slot_valid_reg   <= 1'b1;
                slot_instr_reg   <= word;
                slot_pc_reg      <= pc;
                slot_pc_four_reg <= pc + PC_STEP;
            end else if (skid_valid_reg && !stall) begin
                // Skid drains into the slot before any new fetch is accepted.
                slot_valid_reg   <= 1'b1;
                slot_instr_reg   <= skid_instr_reg;
                slot_pc_reg      <= skid_pc_reg;
                slot_pc_four_reg <= skid_pc_reg + PC_STEP;
                skid_valid_reg   <= 1'b0;
            end else if (!stall) begin
                slot_valid_reg <= 1'b0;
                slot_instr_reg <= NOP_WORD;
            end

            if (skid_load) begin
                skid_valid_reg <= 1'b1;
                skid_instr_reg <= word;
                skid_pc_reg    <= pc;
            end
        end
    end

    assign if_valid       = slot_valid_reg;
    assign if_instruction = slot_instr_reg;
    assign if_pc          = slot_pc_reg;
    assign if_pc_four     = slot_pc_four_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the request/ready handshake
// with instruction memory and feeds the IF/ID slot; handles redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_four,
    output logic        misaligned
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  squash_addr_reg;
    logic         misaligned_reg;

    logic fetch_done;
    logic slot_free;
    logic slot_load;
    logic skid_load;

    assign fetch_done = (state_reg == FS_FETCH) && imem_ready && !redirect;
    assign slot_free  = !if_valid || !stall;
    assign slot_load  = fetch_done && slot_free;
    assign skid_load  = fetch_done && !slot_free;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= FS_START;
            pc_reg          <= RESET_PC;
            squash_addr_reg <= 32'h0;
            misaligned_reg  <= 1'b0;
        end else if (redirect) begin
            pc_reg <= align_word(redirect_pc);
            if (redirect_pc[1:0] != 2'b00)
                misaligned_reg <= 1'b1;
            case (state_reg)
                FS_FETCH: begin
                    // An outstanding request must still be completed, so keep
                    // presenting its address until memory answers.
                    if (imem_ready) begin
                        state_reg <= FS_FETCH;
                    end else begin
                        state_reg       <= FS_DISCARD;
                        squash_addr_reg <= pc_reg;
                    end
                end
                FS_DISCARD: state_reg <= imem_ready ? FS_FETCH : FS_DISCARD;
                default:    state_reg <= FS_FETCH;
            endcase
        end else begin
            case (state_reg)
                FS_START: state_reg <= FS_FETCH;
                FS_FETCH: begin
                    if (imem_ready) begin
                        pc_reg    <= pc_reg + PC_STEP;
                        state_reg <= slot_free ? FS_FETCH : FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (!stall)
                        state_reg <= FS_FETCH;
                end
                FS_DISCARD: begin
                    if (imem_ready)
                        state_reg <= FS_FETCH;
                end
                default: state_reg <= FS_START;
            endcase
        end
    end

    assign imem_req   = (state_reg == FS_FETCH) || (state_reg == FS_DISCARD);
    assign imem_addr  = (state_reg == FS_DISCARD) ? squash_addr_reg : pc_reg;
    assign misaligned = misaligned_reg;

    if_id_register u_if_id (
        .clock          (clock),
        .reset          (reset),
        .flush          (redirect),
        .stall          (stall),
        .load           (slot_load),
        .skid_load      (skid_load),
        .word           (imem_data),
        .pc             (pc_reg),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_pc_four     (if_pc_four)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait streaming, stall/skid, wait
// states, redirect with discard, misaligned redirect, PC wrap and reset.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_four;
    logic        misaligned;

    int n_asserts;
    int n_fails;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_pc_four     (if_pc_four),
        .misaligned     (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: each word is its own address tagged with a constant.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present the word for the current address, then advance one clock.
    task automatic step();
        imem_data = mem_word(imem_addr);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'h0, if_valid}, 32'd1);
        chk({tag, ".pc"}, if_pc, pc);
        chk({tag, ".pc4"}, if_pc_four, pc + 32'd4);
        chk({tag, ".instr"}, if_instruction, mem_word(pc));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid"}, {31'h0, if_valid}, 32'd0);
        chk({tag, ".instr"}, if_instruction, 32'h0);
        chk({tag, ".pc"}, if_pc, 32'h0);
        chk({tag, ".pc4"}, if_pc_four, 32'h0);
        chk({tag, ".misaligned"}, {31'h0, misaligned}, 32'd0);
        chk({tag, ".req"}, {31'h0, imem_req}, 32'd0);
    endtask

    initial begin
        n_asserts   = 0;
        n_fails     = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_data   = 32'h0;

        step();
        step();
        chk_reset_state("reset");

        // Zero-wait memory: START, then one instruction per cycle.
        reset      = 1'b0;
        imem_ready = 1'b1;
        step();
        chk("start.req", {31'h0, imem_req}, 32'd1);
        chk("start.addr", imem_addr, 32'h0);
        chk("start.valid", {31'h0, if_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_slot($sformatf("stream%0d", k), 32'(4 * k));
            $display("stream: if_pc=%h instr=%h", if_pc, if_instruction);
        end

        // Stall while slot holds 8; fetch of 12 lands in the skid.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d.req", k), {31'h0, imem_req}, 32'd0);
            chk_slot($sformatf("hold%0d", k), 32'h8);
        end
        stall = 1'b0;
        step();
        chk_slot("release", 32'hC);
        chk("release.req", {31'h0, imem_req}, 32'd1);
        chk("release.addr", imem_addr, 32'h10);
        step();
        chk_slot("after_release", 32'h10);
        $display("stall/skid: if_pc=%h", if_pc);

        // Two wait cycles per access.
        for (int r = 0; r < 2; r++) begin
            imem_ready = 1'b0;
            step();
            chk($sformatf("wait%0da.valid", r), {31'h0, if_valid}, 32'd0);
            chk($sformatf("wait%0da.addr", r), imem_addr, 32'(32'h14 + 4 * r));
            step();
            chk($sformatf("wait%0db.addr", r), imem_addr, 32'(32'h14 + 4 * r));
            chk($sformatf("wait%0db.req", r), {31'h0, imem_req}, 32'd1);
            imem_ready = 1'b1;
            step();
            chk_slot($sformatf("wait%0d", r), 32'(32'h14 + 4 * r));
            $display("wait: if_pc=%h", if_pc);
        end

        // Redirect to 0x40 while the request for 0x1C is pending.
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        chk("disc.addr", imem_addr, 32'h1C);
        chk("disc.req", {31'h0, imem_req}, 32'd1);
        chk("disc.valid", {31'h0, if_valid}, 32'd0);
        chk("disc.instr", if_instruction, 32'h0);
        step();
        chk("disc2.addr", imem_addr, 32'h1C);
        imem_ready = 1'b1;
        step();
        chk("disc_done.valid", {31'h0, if_valid}, 32'd0);
        chk("disc_done.addr", imem_addr, 32'h40);
        step();
        chk_slot("redir", 32'h40);
        $display("redirect: if_pc=%h", if_pc);

        // Misaligned redirect, taken as a fetch of 0x44 completes.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        chk("mis.flag", {31'h0, misaligned}, 32'd1);
        chk("mis.valid", {31'h0, if_valid}, 32'd0);
        chk("mis.addr", imem_addr, 32'h100);
        step();
        chk_slot("mis", 32'h100);

        // Aligned redirect to the top of memory; PC must wrap to 0.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("top.flag", {31'h0, misaligned}, 32'd1);
        chk("top.addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk_slot("top", 32'hFFFF_FFFC);
        chk("wrap.addr", imem_addr, 32'h0);
        step();
        chk_slot("wrap", 32'h0);
        $display("wrap: if_pc=%h", if_pc);

        // Reset in the middle of a wait.
        imem_ready = 1'b0;
        step();
        chk("prereset.addr", imem_addr, 32'h4);
        reset = 1'b1;
        step();
        chk_reset_state("midreset");
        reset = 1'b0;
        step();
        chk("restart.addr", imem_addr, 32'h0);
        chk("restart.req", {31'h0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        step();
        chk_slot("restart", 32'h0);
        $display("restart: if_pc=%h", if_pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
